gpu_cmd_sequencer: RTL and testbench
====================================

# gpu_cmd_sequencer

Queues complete draw requests (box or character) from the CPU-side bus decoder and issues them one at a time to the GPU fill engine on the 50 MHz video clock. Each request is held in a small FIFO. The sequencer presents all operands to the GPU, pulses the matching draw strobe, and waits for the GPU's `done` flag before it issues the next request. It replaces per-field register pokes with a single atomic request, and adds a hang watchdog and status reporting.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `TIMEOUT`, 131072: maximum cycles spent in WAIT before the watchdog aborts; must be ≥ 4.
- `clk50`  in  1  video/GPU clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reqValid`  in  1  request present on `reqData`.
- `reqData`  in  45  {op[44], x[43:36], y[35:27], xMax[26:19], yMax[18:10], color[9:7], char[6:0]}; op 0 = box, op 1 = char.
- `reqReady`  out  1  FIFO can accept a request this cycle.
- `flush`  in  1  discard all queued (not yet issued) requests.
- `errClear`  in  1  clears `timeoutErr`.
- `gpuDone`  in  1  GPU idle flag; 1 = idle.
- `x` out 8, `y` out 9, `xMax` out 8, `yMax` out 9, `color` out 3, `char` out 7: registered GPU operands.
- `drawBox`  out  1  one-cycle strobe.
- `drawChar`  out  1  one-cycle strobe.
- `busy`  out  1  state ≠ IDLE or FIFO not empty.
- `count`  out  clog2(DEPTH+1)  FIFO occupancy.
- `timeoutErr`  out  1  sticky watchdog flag.

## Operation
- FIFO
  - Circular buffer with read and write pointers that wrap modulo DEPTH.
  - `reqReady = (count < DEPTH)`, computed combinationally with no pop bypass. A full FIFO refuses a push even in the cycle it pops.
  - A push occurs on an edge where `reqValid & reqReady`.
  - If a push and a pop occur on the same edge, `count` is unchanged.
- States: IDLE, LOAD, STROBE, GUARD, WAIT.
  - IDLE → LOAD when `count > 0 & gpuDone & ~flush`. On the same edge the FIFO head is popped into the operand registers.
  - LOAD → STROBE unconditionally. In STROBE, `drawBox` (op = 0) or `drawChar` (op = 1) is high for exactly that one cycle.
  - STROBE → GUARD unconditionally. GUARD gives the GPU one cycle to drop `gpuDone`.
  - GUARD → WAIT unconditionally. The watchdog counter clears to 0 on this edge.
  - In WAIT, `gpuDone = 1` → IDLE. Otherwise the watchdog increments. When it reaches TIMEOUT−1 without `gpuDone`, `timeoutErr` is set and the state returns to IDLE.
- Operand registers change only on the IDLE→LOAD edge. They hold their values through completion and afterwards, until the next LOAD.
- `flush`
  - On an edge with `flush = 1`, both pointers and `count` go to 0, and any same-edge push is discarded.
  - `flush` overrides the IDLE→LOAD pop.
  - An already-issued request (LOAD..WAIT) is unaffected and completes normally.
- `timeoutErr`
  - Set has priority over `errClear` on the same edge.
  - It stays set until an `errClear` edge with no new timeout.
  - It does not block further issue.
- `reset` low forces immediately:
  - state IDLE;
  - pointers, `count`, and watchdog to 0;
  - all operands 0, `drawBox = drawChar = 0`, `timeoutErr = 0`, `busy = 0`;
  - `reqReady = 1`.
- Reset asserted mid-request abandons the request; no strobe is re-issued after release.

## Timing
- Push on edge E0 into an empty, idle FIFO with `gpuDone = 1`:
  - E1: pop, operands valid, LOAD.
  - E2: strobe high during the E2–E3 cycle.
  - E3: GUARD.
  - E4: WAIT.
  - The earliest return to IDLE is E5 if `gpuDone = 1` at that edge.
- Minimum issue-to-issue spacing is 5 cycles: the next LOAD is at E5 + 1 = E6.
- `gpuDone` is ignored in LOAD, STROBE and GUARD. IDLE→LOAD also requires `gpuDone = 1`, so a GPU that is busy for other reasons stalls issue.
- `busy` and `count` are registered-state functions with no extra latency.

## Test plan
- Single box: push {op 0, x 10, y 20, xMax 50, yMax 60, color 3'b101} at E0, GPU holds `gpuDone` low for 8 cycles after the strobe.
  - Operands valid at E1.
  - `drawBox` high for exactly the E2 cycle only; `drawChar` stays 0.
  - Returns to IDLE on the first edge with `gpuDone = 1` in WAIT.
  - `busy` then falls to 0.
- Full/backpressure (DEPTH = 4), GPU busy:
  - Push 5 requests back-to-back: `reqReady` drops after the 4th push and `count = 4`; the 5th is not accepted.
  - Release the GPU: exactly 4 strobes, issued in FIFO order with the correct op per entry.
- Wrap-around: push/drain 10 mixed box/char requests two at a time; every strobe's operands match the pushed order across the pointer wrap.
- Flush during WAIT with 3 queued:
  - `count → 0` on the flush edge.
  - The in-flight request still completes.
  - No further strobes occur.
  - A push on the flush edge is lost.
- Watchdog (TIMEOUT = 16), `gpuDone` stuck 0 after the strobe:
  - `timeoutErr` is set 16 cycles after entering WAIT and the state goes to IDLE.
  - `errClear` pulse → 0.
  - Asserting `errClear` on the same edge as a second timeout leaves it at 1.
- Async reset asserted in STROBE:
  - Strobe drops immediately; all outputs at their reset values, `reqReady = 1`.
  - After release, no strobe occurs without a new push.

Source files
------------

// File: rtl/gpu_cmd_sequencer.sv
// Queues atomic box/char draw requests and issues them one at a time to the GPU fill engine,
// waiting for the GPU done flag between requests and aborting hung requests with a watchdog.
module gpu_cmd_sequencer #(
    parameter  int DEPTH   = 4,
    parameter  int TIMEOUT = 131072,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int WW      = $clog2(TIMEOUT)
) (
    input  logic          i_clk50,
    input  logic          i_reset,
    input  logic          i_reqValid,
    input  logic [44:0]   i_reqData,
    output logic          o_reqReady,
    input  logic          i_flush,
    input  logic          i_errClear,
    input  logic          i_gpuDone,
    output logic [7:0]    o_x,
    output logic [8:0]    o_y,
    output logic [7:0]    o_xMax,
    output logic [8:0]    o_yMax,
    output logic [2:0]    o_color,
    output logic [6:0]    o_char,
    output logic          o_drawBox,
    output logic          o_drawChar,
    output logic          o_busy,
    output logic [CW-1:0] o_count,
    output logic          o_timeoutErr
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STROBE = 3'd2,
        ST_GUARD  = 3'd3,
        ST_WAIT   = 3'd4
    } state_t;

    state_t        r_state;
    logic [44:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [WW-1:0] r_wd;
    logic          r_op;
    logic [7:0]    r_x;
    logic [8:0]    r_y;
    logic [7:0]    r_x_max;
    logic [8:0]    r_y_max;
    logic [2:0]    r_color;
    logic [6:0]    r_char;
    logic          r_draw_box;
    logic          r_draw_char;
    logic          r_timeout_err;

    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_timeout;
    logic [44:0]   w_head;

    // Full FIFO refuses a push even while it pops; flush swallows any same-edge push.
    assign w_ready   = (r_count < CW'(DEPTH));
    assign w_push    = i_reqValid & w_ready & ~i_flush;
    assign w_pop     = (r_state == ST_IDLE) & (r_count != {CW{1'b0}}) & i_gpuDone & ~i_flush;
    assign w_timeout = (r_state == ST_WAIT) & ~i_gpuDone & (r_wd == WW'(TIMEOUT - 1));
    assign w_head    = r_mem[r_rptr];

    // Request storage; contents are only meaningful between the pointers, so no reset is needed.
    always_ff @(posedge i_clk50) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_reqData;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk50 or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (i_flush) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue sequencer: latch operands on pop, strobe once, give the GPU a guard cycle, then wait.
    always_ff @(posedge i_clk50 or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_wd        <= {WW{1'b0}};
            r_op        <= 1'b0;
            r_x         <= 8'd0;
            r_y         <= 9'd0;
            r_x_max     <= 8'd0;
            r_y_max     <= 9'd0;
            r_color     <= 3'd0;
            r_char      <= 7'd0;
            r_draw_box  <= 1'b0;
            r_draw_char <= 1'b0;
        end else begin
            r_draw_box  <= 1'b0;
            r_draw_char <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_LOAD;
                        r_op    <= w_head[44];
                        r_x     <= w_head[43:36];
                        r_y     <= w_head[35:27];
                        r_x_max <= w_head[26:19];
                        r_y_max <= w_head[18:10];
                        r_color <= w_head[9:7];
                        r_char  <= w_head[6:0];
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_state     <= ST_STROBE;
                    r_draw_box  <= ~r_op;
                    r_draw_char <= r_op;
                end
                ST_STROBE: begin
                    r_state <= ST_GUARD;
                end
                ST_GUARD: begin
                    r_state <= ST_WAIT;
                    r_wd    <= {WW{1'b0}};
                end
                ST_WAIT: begin
                    if (i_gpuDone || w_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wd <= r_wd + WW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky watchdog flag; a fresh timeout wins over a simultaneous clear.
    always_ff @(posedge i_clk50 or negedge i_reset) begin
        if (!i_reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end else if (i_errClear) begin
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= r_timeout_err;
        end
    end

    assign o_reqReady   = w_ready;
    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_xMax       = r_x_max;
    assign o_yMax       = r_y_max;
    assign o_color      = r_color;
    assign o_char       = r_char;
    assign o_drawBox    = r_draw_box;
    assign o_drawChar   = r_draw_char;
    assign o_busy       = (r_state != ST_IDLE) | (r_count != {CW{1'b0}});
    assign o_count      = r_count;
    assign o_timeoutErr = r_timeout_err;

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Scoreboard bench for gpu_cmd_sequencer: directed scenarios plus random traffic against a
// timeline reference model (cycles since issue) kept in the bench.
module tb_gpu_cmd_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [44:0]   req_data = 45'd0;
    logic          flush = 1'b0;
    logic          err_clear = 1'b0;
    logic          gpu_done = 1'b1;
    logic          o_reqReady;
    logic [7:0]    o_x;
    logic [8:0]    o_y;
    logic [7:0]    o_xMax;
    logic [8:0]    o_yMax;
    logic [2:0]    o_color;
    logic [6:0]    o_char;
    logic          o_drawBox;
    logic          o_drawChar;
    logic          o_busy;
    logic [CW-1:0] o_count;
    logic          o_timeoutErr;

    gpu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk50(clk), .i_reset(rst_n), .i_reqValid(req_valid), .i_reqData(req_data),
        .o_reqReady(o_reqReady), .i_flush(flush), .i_errClear(err_clear), .i_gpuDone(gpu_done),
        .o_x(o_x), .o_y(o_y), .o_xMax(o_xMax), .o_yMax(o_yMax), .o_color(o_color),
        .o_char(o_char), .o_drawBox(o_drawBox), .o_drawChar(o_drawChar), .o_busy(o_busy),
        .o_count(o_count), .o_timeoutErr(o_timeoutErr)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int n_strobe = 0;

    // Reference model: pending requests, expected issue order, and cycles elapsed since issue.
    logic [44:0] m_q[$];
    logic [44:0] exp_q[$];
    int          m_age = 0;
    bit          m_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [44:0] rnd_req();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[44:0];
    endfunction

    // Model step: age 1 = LOAD, 2 = strobe cycle, 3 = guard, >= 4 = waiting (watchdog = age - 4).
    initial begin
        bit acc, iss, tmo;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                exp_q.delete();
                m_age = 0;
                m_err = 1'b0;
            end else begin
                acc = req_valid && (m_q.size() < DEPTH) && !flush;
                iss = (m_age == 0) && (m_q.size() > 0) && gpu_done && !flush;
                tmo = (m_age >= 4) && !gpu_done && (m_age - 4 == TIMEOUT - 1);
                if (flush) m_q.delete();
                else begin
                    if (iss) exp_q.push_back(m_q.pop_front());
                    if (acc) m_q.push_back(req_data);
                end
                if (iss) m_age = 1;
                else if (m_age >= 4 && (gpu_done || tmo)) m_age = 0;
                else if (m_age > 0) m_age++;
                if (tmo) m_err = 1'b1;
                else if (err_clear) m_err = 1'b0;
            end
        end
    end

    // Monitor: per-cycle status against the model, strobe operands against the scoreboard.
    initial begin
        logic [44:0] e;
        forever begin
            @(negedge clk);
            chk("strobe", 64'(o_drawBox | o_drawChar), 64'(m_age == 2));
            chk("count", 64'(o_count), 64'(m_q.size()));
            chk("ready", 64'(o_reqReady), 64'(m_q.size() < DEPTH));
            chk("busy", 64'(o_busy), 64'(m_age != 0 || m_q.size() > 0));
            chk("timeout_err", 64'(o_timeoutErr), 64'(m_err));
            if (o_drawBox || o_drawChar) begin
                n_strobe++;
                if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
                else begin
                    e = exp_q.pop_front();
                    chk("op_box", 64'(o_drawBox), 64'(!e[44]));
                    chk("op_char", 64'(o_drawChar), 64'(e[44]));
                    chk("x", 64'(o_x), 64'(e[43:36]));
                    chk("y", 64'(o_y), 64'(e[35:27]));
                    chk("xmax", 64'(o_xMax), 64'(e[26:19]));
                    chk("ymax", 64'(o_yMax), 64'(e[18:10]));
                    chk("color", 64'(o_color), 64'(e[9:7]));
                    chk("char", 64'(o_char), 64'(e[6:0]));
                end
            end
        end
    end

    task automatic push(input logic [44:0] d);
        req_valid = 1'b1;
        req_data  = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (o_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (o_busy) chk("idle_wait", 64'(o_busy), 64'd0);
    endtask

    initial begin
        int s0;
        int k;
        #5;
        chk("rst_ready", 64'(o_reqReady), 64'd1);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_strobes", 64'({o_drawBox, o_drawChar}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single box, GPU busy for 8 cycles after the strobe
        push({1'b0, 8'd10, 9'd20, 8'd50, 9'd60, 3'b101, 7'd0});
        @(negedge clk);
        chk("box_load_x", 64'(o_x), 64'd10);
        @(negedge clk);
        chk("box_strobe", 64'({o_drawBox, o_drawChar}), 64'b10);
        gpu_done = 1'b0;
        repeat (8) @(negedge clk);
        gpu_done = 1'b1;
        wait_idle();

        // Backpressure with the GPU busy
        gpu_done = 1'b0;
        repeat (5) begin
            req_valid = 1'b1;
            req_data  = rnd_req();
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("full_count", 64'(o_count), 64'd4);
        chk("full_ready", 64'(o_reqReady), 64'd0);
        s0 = n_strobe;
        gpu_done = 1'b1;
        repeat (40) @(negedge clk);
        chk("full_strobes", 64'(n_strobe - s0), 64'd4);

        // Pointer wrap-around, two requests at a time
        repeat (5) begin
            push(rnd_req());
            push(rnd_req());
            wait_idle();
        end

        // Flush while one request is waiting and three are queued
        s0 = n_strobe;
        push(rnd_req());
        @(negedge clk);
        gpu_done = 1'b0;
        repeat (3) begin
            req_valid = 1'b1;
            req_data  = rnd_req();
            @(negedge clk);
        end
        flush     = 1'b1;
        req_data  = rnd_req();
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_count", 64'(o_count), 64'd0);
        repeat (3) @(negedge clk);
        gpu_done = 1'b1;
        repeat (20) @(negedge clk);
        chk("flush_strobes", 64'(n_strobe - s0), 64'd1);

        // Watchdog with gpuDone stuck low
        push(rnd_req());
        @(negedge clk);
        gpu_done = 1'b0;
        repeat (25) @(negedge clk);
        chk("wd_err", 64'(o_timeoutErr), 64'd1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("wd_clear", 64'(o_timeoutErr), 64'd0);
        gpu_done = 1'b1;
        push(rnd_req());
        @(negedge clk);
        gpu_done  = 1'b0;
        err_clear = 1'b1;
        k = 0;
        while (!o_timeoutErr && k < 40) begin
            @(negedge clk);
            k++;
        end
        err_clear = 1'b0;
        if (!o_timeoutErr) chk("wd_prio_wait", 64'(o_timeoutErr), 64'd1);
        @(negedge clk);
        chk("wd_prio", 64'(o_timeoutErr), 64'd1);
        gpu_done = 1'b1;

        // Asynchronous reset during the strobe cycle
        push({1'b1, 8'hA5, 9'h155, 8'h3C, 9'h0F0, 3'b011, 7'h55});
        k = 0;
        while (!(o_drawBox || o_drawChar) && k < 10) begin
            @(negedge clk);
            k++;
        end
        #3 rst_n = 1'b0;
        #1;
        chk("arst_strobes", 64'({o_drawBox, o_drawChar}), 64'd0);
        chk("arst_ready", 64'(o_reqReady), 64'd1);
        chk("arst_busy", 64'(o_busy), 64'd0);
        chk("arst_err", 64'(o_timeoutErr), 64'd0);
        chk("arst_ops", 64'({o_x, o_y, o_xMax, o_yMax, o_color, o_char}), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        s0 = n_strobe;
        @(negedge clk);
        repeat (10) @(negedge clk);
        chk("arst_no_strobe", 64'(n_strobe - s0), 64'd0);

        // Random traffic
        repeat (1200) begin
            req_valid = ($urandom_range(0, 99) < 40);
            req_data  = rnd_req();
            flush     = ($urandom_range(0, 99) < 3);
            err_clear = ($urandom_range(0, 99) < 5);
            if (gpu_done) gpu_done = ($urandom_range(0, 99) >= 15);
            else          gpu_done = ($urandom_range(0, 99) < 8);
            @(negedge clk);
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        err_clear = 1'b0;
        gpu_done  = 1'b1;
        repeat (40) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("final_idle", 64'(o_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
